// File: rtl/level_stack_if.sv
// Interrupt request handshake between the interrupt arbiter and level_stack.
//   intReq  : request valid, held by the arbiter until intAck
//   intPrio : priority of the pending request (0 = thread mode, never taken)
//   intAddr : handler entry address
//   intAck  : one-cycle pulse when the request has been taken
// master = arbiter side, slave = level_stack side.
interface level_stack_if #(
    parameter int NumLevels = 8,
    parameter int PcWidth   = 32
);
    localparam int LevelsWidth = $clog2(NumLevels);

    logic                   intReq;
    logic [LevelsWidth-1:0] intPrio;
    logic [PcWidth-1:0]     intAddr;
    logic                   intAck;

    modport master (output intReq, output intPrio, output intAddr, input intAck);
    modport slave  (input intReq, input intPrio, input intAddr, output intAck);
endinterface

// File: rtl/level_stack.sv
// level_stack: interrupt nesting controller for the banked register-file stack.
// Takes prioritised requests, pushes {previous level, return pc} onto an
// internal stack, redirects fetch to the handler, and pops the stack when the
// core jumps to the ra marker.
// Ports:
//   clk          clock, all state on rising edge
//   reset        asynchronous, active-low reset
//   intBus       request handshake (intReq/intPrio/intAddr in, intAck out)
//   pcIn         pc of the next instruction, saved on entry
//   retEn        core jumps to the ra marker (1-cycle pulse)
//   level        current level to the register-file stack
//   writeRaEn    write ra marker into the new bank (1-cycle pulse)
//   pcOverrideEn fetch redirect valid (1-cycle pulse)
//   pcOverride   fetch redirect target
//   depth        number of stacked entries
//   stackErr     sticky: return seen with an empty stack
module level_stack #(
    parameter  int NumLevels   = 8,
    parameter  int PcWidth     = 32,
    localparam int LevelsWidth = $clog2(NumLevels)
) (
    input  logic                   clk,
    input  logic                   reset,
    level_stack_if.slave           intBus,
    input  logic [PcWidth-1:0]     pcIn,
    input  logic                   retEn,
    output logic [LevelsWidth-1:0] level,
    output logic                   writeRaEn,
    output logic                   pcOverrideEn,
    output logic [PcWidth-1:0]     pcOverride,
    output logic [LevelsWidth-1:0] depth,
    output logic                   stackErr
);
    typedef enum logic [1:0] {RUN, ENTER, EXIT} state_t;

    state_t                 state;
    // Strictly rising priorities bound nesting to NumLevels-1 entries.
    logic [LevelsWidth-1:0] stackLevel [NumLevels-1];
    logic [PcWidth-1:0]     stackPc    [NumLevels-1];
    logic [LevelsWidth-1:0] topIdx;

    assign topIdx = depth - LevelsWidth'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= RUN;
            level         <= '0;
            depth         <= '0;
            intBus.intAck <= 1'b0;
            writeRaEn     <= 1'b0;
            pcOverrideEn  <= 1'b0;
            pcOverride    <= '0;
            stackErr      <= 1'b0;
            for (int i = 0; i < NumLevels - 1; i++) begin
                stackLevel[i] <= '0;
                stackPc[i]    <= '0;
            end
        end else begin
            // Pulses default low; only the RUN decisions raise them for one cycle.
            intBus.intAck <= 1'b0;
            writeRaEn     <= 1'b0;
            pcOverrideEn  <= 1'b0;
            case (state)
                RUN: begin
                    // A return takes precedence; a concurrent request stays pending.
                    if (retEn) begin
                        if (depth != '0) begin
                            depth        <= topIdx;
                            level        <= stackLevel[topIdx];
                            pcOverride   <= stackPc[topIdx];
                            pcOverrideEn <= 1'b1;
                            state        <= EXIT;
                        end else begin
                            stackErr <= 1'b1;
                        end
                    end else if (intBus.intReq && (intBus.intPrio > level)) begin
                        stackLevel[depth] <= level;
                        stackPc[depth]    <= pcIn;
                        depth             <= depth + LevelsWidth'(1);
                        level             <= intBus.intPrio;
                        pcOverride        <= intBus.intAddr;
                        intBus.intAck     <= 1'b1;
                        writeRaEn         <= 1'b1;
                        pcOverrideEn      <= 1'b1;
                        state             <= ENTER;
                    end
                end
                // One-cycle states: outputs were set on the way in; nothing is taken here.
                ENTER:   state <= RUN;
                EXIT:    state <= RUN;
                default: state <= RUN;
            endcase
        end
    end
endmodule
